// File: rtl/vertex_xform_pipe_if.sv
// Primitive-in / transformed-primitive-out bundle for vertex_xform_pipe.
// slave modport: the vertex stage (consumes primitives, produces results).
// master modport: the environment (primitive fetch upstream + rasteriser downstream).
interface vertex_xform_pipe_if #(
    parameter int WIDTH = 32,
    parameter int NVERT = 3
);
    // upstream primitive
    logic [15:0][WIDTH-1:0]           mat;       // row-major, mat[4r+c]
    logic [NVERT-1:0][2:0][WIDTH-1:0] v_in;      // [vertex][x,y,z]
    logic [NVERT-1:0][23:0]           color_in;  // RGB888, R in [23:16]
    logic [2:0][WIDTH-1:0]            normal;
    logic [2:0][WIDTH-1:0]            light;
    logic                             done_in;
    logic                             in_valid;
    logic                             in_ready;
    // downstream primitive
    logic [NVERT-1:0][WIDTH-1:0]      x_out;
    logic [NVERT-1:0][WIDTH-1:0]      y_out;
    logic [NVERT-1:0][WIDTH-1:0]      z_out;
    logic [NVERT-1:0][WIDTH-1:0]      w_out;
    logic [NVERT-1:0]                 clip_out;
    logic [NVERT-1:0][23:0]           color_out;
    logic                             done_out;
    logic                             out_valid;
    logic                             out_ready;

    modport slave (
        input  mat, v_in, color_in, normal, light, done_in, in_valid, out_ready,
        output in_ready, x_out, y_out, z_out, w_out, clip_out, color_out, done_out, out_valid
    );

    modport master (
        output mat, v_in, color_in, normal, light, done_in, in_valid, out_ready,
        input  in_ready, x_out, y_out, z_out, w_out, clip_out, color_out, done_out, out_valid
    );
endinterface

// File: rtl/vertex_xform_pipe.sv
// Purpose: transform NVERT vertices by a 4x4 fixed-point matrix (w=1), flag clipping,
//          map x/y to screen space, optionally light the vertex colour.
// Latency: out_valid rises NVERT+1 edges after accept; one primitive per NVERT+3 cycles.
// Backpressure: outputs held while out_valid && !out_ready; in_ready only in IDLE.
//
// Ports: clock, reset (async, active-low), io (vertex_xform_pipe_if.slave) carrying the
//        input primitive (mat, v_in, color_in, normal, light, done_in, in_valid/in_ready)
//        and the output primitive (x/y/z/w_out, clip_out, color_out, done_out, out_valid/out_ready).
// Optional feature: define VERTEX_XFORM_LIGHTING_EN to scale colour by clamped N.L;
//        otherwise colour passes through and normal/light are ignored.
module vertex_xform_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int NVERT  = 3,
    parameter int HALF_W = 320,
    parameter int HALF_H = 240
) (
    input  logic                  clock,
    input  logic                  reset,
    vertex_xform_pipe_if.slave    io
);
    localparam int VW = (NVERT > 1) ? $clog2(NVERT) : 1;

    typedef logic signed [WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, XFORM, FINISH, HOLD} state_t;

    localparam word_t HW_FX = word_t'(HALF_W) << FRAC;
    localparam word_t HH_FX = word_t'(HALF_H) << FRAC;

    // Full-width signed product, arithmetic shift back to the fixed-point scale.
    function automatic word_t fp_mul(input word_t a, input word_t b);
        logic signed [2*WIDTH-1:0] ae, be, p;
        ae = {{WIDTH{a[WIDTH-1]}}, a};
        be = {{WIDTH{b[WIDTH-1]}}, b};
        p  = ae * be;
        return word_t'(p >>> FRAC);
    endfunction

    state_t            state;
    logic [VW-1:0]     vidx;
    word_t             mat_q [16];
    word_t             v_q   [NVERT][3];
    logic [23:0]       col_q [NVERT];
    logic              done_q;
    logic [NVERT-1:0]  clip_q;
    // pre-viewport results, consumed by FINISH
    word_t             xs [NVERT];
    word_t             ys [NVERT];
    word_t             zs [NVERT];
    word_t             ws [NVERT];

    assign io.in_ready = (state == IDLE) && reset;

    // Shared 4-row dot-product unit on the vertex selected by vidx.
    word_t row_res [4];
    logic  clip_cur;
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_res[r] = fp_mul(mat_q[4*r],   v_q[vidx][0])
                       + fp_mul(mat_q[4*r+1], v_q[vidx][1])
                       + fp_mul(mat_q[4*r+2], v_q[vidx][2])
                       + mat_q[4*r+3];
        end
        // |x|>w written as x>w or x<-w; -w cannot overflow once w>0 holds.
        clip_cur = (row_res[3] <= '0)
                 | (row_res[0] > row_res[3]) | (row_res[0] < -row_res[3])
                 | (row_res[1] > row_res[3]) | (row_res[1] < -row_res[3]);
    end

    logic [23:0] col_fin [NVERT];

`ifdef VERTEX_XFORM_LIGHTING_EN
    word_t nrm_q [3];
    word_t lgt_q [3];
    word_t cos_raw, cos_cl;

    function automatic logic [7:0] scale_ch(input logic [7:0] ch, input word_t c);
        logic [FRAC+8:0] p;
        p = (FRAC+9)'(ch) * (FRAC+9)'(c[FRAC:0]);
        return 8'(p >> FRAC);
    endfunction

    always_comb begin
        cos_raw = fp_mul(nrm_q[0], lgt_q[0]) + fp_mul(nrm_q[1], lgt_q[1])
                + fp_mul(nrm_q[2], lgt_q[2]);
        if (cos_raw < '0)
            cos_cl = '0;
        else if (cos_raw > (word_t'(1) << FRAC))
            cos_cl = word_t'(1) << FRAC;
        else
            cos_cl = cos_raw;
        for (int i = 0; i < NVERT; i++) begin
            col_fin[i] = {scale_ch(col_q[i][23:16], cos_cl),
                          scale_ch(col_q[i][15:8],  cos_cl),
                          scale_ch(col_q[i][7:0],   cos_cl)};
        end
    end
`else
    logic unused_light_ok;
    assign unused_light_ok = ^{io.normal, io.light};

    always_comb begin
        for (int i = 0; i < NVERT; i++) col_fin[i] = col_q[i];
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            vidx   <= '0;
            done_q <= 1'b0;
            clip_q <= '0;
            for (int k = 0; k < 16; k++) mat_q[k] <= '0;
            for (int i = 0; i < NVERT; i++) begin
                for (int c = 0; c < 3; c++) v_q[i][c] <= '0;
                col_q[i]        <= '0;
                xs[i]           <= '0;
                ys[i]           <= '0;
                zs[i]           <= '0;
                ws[i]           <= '0;
                io.x_out[i]     <= '0;
                io.y_out[i]     <= '0;
                io.z_out[i]     <= '0;
                io.w_out[i]     <= '0;
                io.color_out[i] <= '0;
            end
`ifdef VERTEX_XFORM_LIGHTING_EN
            for (int c = 0; c < 3; c++) begin
                nrm_q[c] <= '0;
                lgt_q[c] <= '0;
            end
`endif
            io.clip_out  <= '0;
            io.done_out  <= 1'b0;
            io.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        for (int k = 0; k < 16; k++) mat_q[k] <= io.mat[k];
                        for (int i = 0; i < NVERT; i++) begin
                            for (int c = 0; c < 3; c++) v_q[i][c] <= io.v_in[i][c];
                            col_q[i] <= io.color_in[i];
                        end
`ifdef VERTEX_XFORM_LIGHTING_EN
                        for (int c = 0; c < 3; c++) begin
                            nrm_q[c] <= io.normal[c];
                            lgt_q[c] <= io.light[c];
                        end
`endif
                        done_q <= io.done_in;
                        vidx   <= '0;
                        state  <= XFORM;
                    end
                end
                XFORM: begin
                    xs[vidx]     <= row_res[0];
                    ys[vidx]     <= row_res[1];
                    zs[vidx]     <= row_res[2];
                    ws[vidx]     <= row_res[3];
                    clip_q[vidx] <= clip_cur;
                    if (vidx == VW'(NVERT-1))
                        state <= FINISH;
                    else
                        vidx <= vidx + 1'b1;
                end
                FINISH: begin
                    for (int i = 0; i < NVERT; i++) begin
                        io.x_out[i]     <= fp_mul(xs[i], HW_FX) + HW_FX;
                        io.y_out[i]     <= fp_mul(ys[i], HH_FX) + HH_FX;
                        io.z_out[i]     <= zs[i];
                        io.w_out[i]     <= ws[i];
                        io.color_out[i] <= col_fin[i];
                    end
                    io.clip_out  <= clip_q;
                    io.done_out  <= done_q;
                    io.out_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    // IDLE is entered first, so no accept can coincide with this handoff.
                    if (io.out_ready) begin
                        io.out_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vertex_xform_pipe.sv
module tb_vertex_xform_pipe;
    localparam int ONE = 65536;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    vertex_xform_pipe_if #(.WIDTH(32), .NVERT(3)) io ();

    vertex_xform_pipe #(
        .WIDTH(32), .FRAC(16), .NVERT(3), .HALF_W(320), .HALF_H(240)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (io.slave)
    );

    int checks = 0;
    int errors = 0;

    // stimulus for the next primitive
    int          mat [16];
    int          vx  [3][3];
    logic [23:0] col [3];
    int          nrm [3];
    int          lgt [3];
    bit          dn;

    // expected outputs
    logic [2:0][31:0] ex_x, ex_y, ex_z, ex_w;
    logic [2:0][23:0] ex_col;
    logic [2:0]       ex_clip;
    logic             ex_done;

    function automatic int fp(int a, int b);
        longint p = longint'(a) * longint'(b);
        return int'(p >>> 16);
    endfunction

    function automatic longint abs64(int a);
        return (a < 0) ? -longint'(a) : longint'(a);
    endfunction

    // Homogeneous matrix-vector product with w=1, then clip test and viewport.
    function automatic void ref_model();
        int vh [4];
        int res [4];
        int cs;
        int r8, g8, b8;
        for (int i = 0; i < 3; i++) begin
            vh = '{vx[i][0], vx[i][1], vx[i][2], ONE};
            for (int r = 0; r < 4; r++) begin
                res[r] = 0;
                for (int c = 0; c < 4; c++) res[r] += fp(mat[4*r+c], vh[c]);
            end
            ex_clip[i] = (res[3] <= 0) || (abs64(res[0]) > longint'(res[3]))
                                       || (abs64(res[1]) > longint'(res[3]));
            ex_x[i] = fp(res[0], 320 * ONE) + 320 * ONE;
            ex_y[i] = fp(res[1], 240 * ONE) + 240 * ONE;
            ex_z[i] = res[2];
            ex_w[i] = res[3];
`ifdef VERTEX_XFORM_LIGHTING_EN
            cs = fp(nrm[0], lgt[0]) + fp(nrm[1], lgt[1]) + fp(nrm[2], lgt[2]);
            if (cs < 0) cs = 0;
            if (cs > ONE) cs = ONE;
            r8 = int'(col[i][23:16]) * cs / ONE;
            g8 = int'(col[i][15:8])  * cs / ONE;
            b8 = int'(col[i][7:0])   * cs / ONE;
            ex_col[i] = {8'(r8), 8'(g8), 8'(b8)};
`else
            cs = 0; r8 = 0; g8 = 0; b8 = 0;
            ex_col[i] = col[i];
`endif
        end
        ex_done = dn;
    endfunction

    function automatic void set_identity();
        for (int k = 0; k < 16; k++) mat[k] = (k % 5 == 0) ? ONE : 0;
    endfunction

    function automatic void set_all_verts(int x, int y, int z);
        for (int i = 0; i < 3; i++) vx[i] = '{x, y, z};
    endfunction

    task automatic drive_inputs();
        for (int k = 0; k < 16; k++) io.mat[k] = mat[k];
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) io.v_in[i][c] = vx[i][c];
            io.color_in[i] = col[i];
        end
        for (int c = 0; c < 3; c++) begin
            io.normal[c] = nrm[c];
            io.light[c]  = lgt[c];
        end
        io.done_in = dn;
    endtask

    task automatic scramble_inputs();
        for (int k = 0; k < 16; k++) io.mat[k] = $urandom;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 3; c++) io.v_in[i][c] = $urandom;
            io.color_in[i] = 24'($urandom);
        end
        for (int c = 0; c < 3; c++) begin
            io.normal[c] = $urandom;
            io.light[c]  = $urandom;
        end
        io.done_in = ~dn;
    endtask

    // Offer one primitive, scramble inputs after accept, return #1 after out_valid rises.
    task automatic run_prim(output int lat, output bit ok);
        int guard = 0;
        ok  = 1'b1;
        lat = 0;
        ref_model();
        @(negedge clock);
        while (!io.in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (!io.in_ready) begin
            ok = 1'b0;
            return;
        end
        drive_inputs();
        io.in_valid = 1'b1;
        @(posedge clock);
        #1;
        io.in_valid = 1'b0;
        scramble_inputs();
        while (!io.out_valid && lat < 50) begin
            @(posedge clock);
            lat++;
            #1;
        end
        if (!io.out_valid) ok = 1'b0;
    endtask

    task automatic release_prim();
        int g = 0;
        @(negedge clock);
        io.out_ready = 1'b1;
        while (io.out_valid && g < 20) begin
            @(posedge clock);
            #1;
            g++;
        end
        checks++;
        if (io.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release: out_valid=%b still high after %0d cycles", io.out_valid, g);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        dn = 1'b0;
        scramble_inputs();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (io.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset in_ready: got %b want 0", io.in_ready);
        end
        checks++;
        if (io.out_valid !== 1'b0 || io.done_out !== 1'b0) begin
            errors++; $display("FAIL reset valid/done: got %b/%b want 0/0", io.out_valid, io.done_out);
        end
        checks++;
        if (io.x_out !== '0 || io.clip_out !== '0 || io.color_out !== '0) begin
            errors++; $display("FAIL reset data: x=%h clip=%b col=%h want 0", io.x_out, io.clip_out, io.color_out);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (io.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset release in_ready: got %b want 1", io.in_ready);
        end
    endtask

    task automatic test_identity();
        int lat; bit ok;
        set_identity();
        set_all_verts(ONE, 2 * ONE, 3 * ONE);
        col = '{24'h112233, 24'h445566, 24'h778899};
        nrm = '{0, 0, ONE}; lgt = '{0, 0, ONE};
        dn = 1'b0;
        io.out_ready = 1'b1;
        run_prim(lat, ok);
        checks++;
        if (!ok || lat != 4) begin
            errors++; $display("FAIL identity latency: got %0d (ok=%b) want 4", lat, ok);
        end
        checks++;
        if (io.x_out[0] !== 32'(640 * ONE) || io.y_out[1] !== 32'(720 * ONE)
            || io.z_out[2] !== 32'h30000 || io.w_out[0] !== 32'h10000) begin
            errors++; $display("FAIL identity values: x=%h y=%h z=%h w=%h", io.x_out[0], io.y_out[1], io.z_out[2], io.w_out[0]);
        end
        // y=2.0 exceeds w=1.0, so every vertex is clipped
        checks++;
        if (io.clip_out !== 3'b111 || io.clip_out !== ex_clip) begin
            errors++; $display("FAIL identity clip: got %b want %b", io.clip_out, ex_clip);
        end
        checks++;
        if (io.x_out !== ex_x || io.y_out !== ex_y || io.z_out !== ex_z || io.w_out !== ex_w) begin
            errors++; $display("FAIL identity buses: x=%h want %h", io.x_out, ex_x);
        end
        release_prim();
    endtask

    task automatic test_clip();
        int lat; bit ok;
        set_identity();
        vx[0] = '{2 * ONE, 0, 0};
        vx[1] = '{0, -ONE, 0};
        vx[2] = '{0, 0, 0};
        for (int m = 0; m < 2; m++) begin
            mat[15] = (m == 0) ? 0 : ONE;
            run_prim(lat, ok);
            checks++;
            if (!ok || io.clip_out !== ((m == 0) ? 3'b111 : 3'b001)) begin
                errors++; $display("FAIL clip mat15=%0d: got %b want %b", mat[15], io.clip_out, (m == 0) ? 3'b111 : 3'b001);
            end
            release_prim();
        end
    endtask

    task automatic test_offset();
        int lat; bit ok;
        set_identity();
        set_all_verts(0, 0, 0);
        mat[3] = 32'h8000;
        mat[7] = -ONE;
        run_prim(lat, ok);
        checks++;
        if (!ok || io.x_out[1] !== 32'(480 * ONE)) begin
            errors++; $display("FAIL offset x_out: got %h want %h", io.x_out[1], 32'(480 * ONE));
        end
        checks++;
        if (io.y_out[2] !== 32'h0) begin
            errors++; $display("FAIL offset y_out: got %h want 0", io.y_out[2]);
        end
        release_prim();
    endtask

    task automatic test_backpressure();
        int lat; bit ok;
        logic [2:0][31:0] snap_x;
        set_identity();
        set_all_verts(ONE / 2, -ONE / 4, ONE);
        dn = 1'b1;
        io.out_ready = 1'b0;
        run_prim(lat, ok);
        snap_x = io.x_out;
        checks++;
        if (!ok || snap_x !== ex_x) begin
            errors++; $display("FAIL stall first x_out: got %h want %h", snap_x, ex_x);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.x_out !== snap_x
                || io.done_out !== 1'b1) begin
                errors++; $display("FAIL stall cycle %0d: valid=%b in_ready=%b done=%b x=%h", c, io.out_valid, io.in_ready, io.done_out, io.x_out);
            end
        end
        @(negedge clock);
        io.out_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.done_out !== 1'b1) begin
            errors++; $display("FAIL stall release: valid=%b in_ready=%b done=%b want 0/1/1", io.out_valid, io.in_ready, io.done_out);
        end
        dn = 1'b0;
    endtask

    task automatic test_lighting();
        int lat; bit ok;
        logic [23:0] want;
        set_identity();
        set_all_verts(ONE, 2 * ONE, 3 * ONE);
        col = '{24'hFF8040, 24'hFF8040, 24'hFF8040};
        nrm = '{0, 0, ONE};
        for (int m = 0; m < 2; m++) begin
            lgt = (m == 0) ? '{0, 0, ONE / 2} : '{0, 0, -ONE};
`ifdef VERTEX_XFORM_LIGHTING_EN
            want = (m == 0) ? 24'h7F4020 : 24'h000000;
`else
            want = 24'hFF8040;
`endif
            run_prim(lat, ok);
            checks++;
            if (!ok || io.color_out[0] !== want || io.color_out !== ex_col) begin
                errors++; $display("FAIL lighting case %0d: got %h want %h", m, io.color_out[0], want);
            end
            release_prim();
        end
    endtask

    task automatic test_reset_mid();
        int lat; bit ok;
        set_identity();
        set_all_verts(ONE, 2 * ONE, 3 * ONE);
        @(negedge clock);
        drive_inputs();
        io.in_valid = 1'b1;
        @(posedge clock);
        #1;
        io.in_valid = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (io.out_valid !== 1'b0 || io.in_ready !== 1'b0 || io.x_out !== '0) begin
            errors++; $display("FAIL mid reset: valid=%b in_ready=%b x=%h want 0/0/0", io.out_valid, io.in_ready, io.x_out);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (io.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid reset release in_ready: got %b want 1", io.in_ready);
        end
        set_all_verts(ONE / 2, ONE / 2, ONE);
        run_prim(lat, ok);
        checks++;
        if (!ok || lat != 4 || io.x_out !== ex_x || io.y_out !== ex_y || io.clip_out !== ex_clip) begin
            errors++; $display("FAIL mid reset recovery: lat=%0d x=%h want %h", lat, io.x_out, ex_x);
        end
        release_prim();
    endtask

    task automatic test_back_to_back();
        int cyc = 0, a0 = -1, a1 = -1;
        set_identity();
        set_all_verts(ONE, ONE, ONE);
        @(negedge clock);
        drive_inputs();
        io.in_valid = 1'b1;
        io.out_ready = 1'b1;
        while (a1 < 0 && cyc < 60) begin
            if (io.in_ready) begin
                if (a0 < 0) a0 = cyc; else a1 = cyc;
            end
            @(negedge clock);
            cyc++;
        end
        io.in_valid = 1'b0;
        checks++;
        if (a1 < 0 || a1 - a0 != 6) begin
            errors++; $display("FAIL back_to_back spacing: got %0d want 6", a1 - a0);
        end
        repeat (10) @(posedge clock);
        release_prim();
    endtask

    function automatic int rnd_fx(int range);
        return int'($urandom_range(0, 2 * range)) - range;
    endfunction

    task automatic test_random();
        int lat; bit ok;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < 16; k++) mat[k] = rnd_fx(2 * ONE);
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 3; c++) vx[i][c] = rnd_fx(3 * ONE);
                col[i] = 24'($urandom);
            end
            for (int c = 0; c < 3; c++) begin
                nrm[c] = rnd_fx(ONE);
                lgt[c] = rnd_fx(ONE);
            end
            dn = 1'($urandom);
            io.out_ready = 1'($urandom);
            run_prim(lat, ok);
            checks++;
            if (!ok || lat != 4) begin
                errors++; $display("FAIL random %0d latency: got %0d want 4", t, lat);
            end
            checks++;
            if (io.x_out !== ex_x || io.y_out !== ex_y || io.z_out !== ex_z || io.w_out !== ex_w) begin
                errors++; $display("FAIL random %0d coords: x=%h/%h y=%h/%h", t, io.x_out, ex_x, io.y_out, ex_y);
            end
            checks++;
            if (io.clip_out !== ex_clip || io.color_out !== ex_col || io.done_out !== ex_done) begin
                errors++; $display("FAIL random %0d clip/col/done: got %b %h %b want %b %h %b", t, io.clip_out, io.color_out, io.done_out, ex_clip, ex_col, ex_done);
            end
            release_prim();
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_clip();
        test_offset();
        test_backpressure();
        test_lighting();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
